pet2001_char_shifter: RTL

//  Character-generation / pixel-serialiser stage downstream of the PET video timing

---
 rtl/pet2001_char_shifter_if.sv | 42 ++++
 rtl/pet2001_char_shifter.sv | 120 ++++++++++++
 2 files changed

// File: rtl/pet2001_char_shifter_if.sv
// Video-side bundle between the PET timing/CRTC path, the video RAM, the character ROM and the pixel sink.
// The master side is the timing source plus the memories; the slave side is the character shifter.
interface pet2001_char_shifter_if #(
  parameter int VRAM_AW = 10
);
  // Character timing from the video timing generator / CRTC mux
  logic [13:0]        vid_ma;
  logic [4:0]         vid_ra;
  logic               vid_de;
  logic               vid_cursor;
  logic               vid_hblank;
  logic               vid_vblank;
  logic               vid_hsync;
  logic               vid_vsync;
  logic               video_blank;
  logic               video_gfx;

  // Memory fetch path (both memories are synchronous, one ce_1m period of latency)
  logic [VRAM_AW-1:0] vram_addr;
  logic [7:0]         vram_data;
  logic [10:0]        chrom_addr;
  logic [7:0]         chrom_data;

  // Serialised pixel stream and aligned blank/sync
  logic               pix;
  logic               out_hblank;
  logic               out_vblank;
  logic               out_hsync;
  logic               out_vsync;

  modport master (
    output vid_ma, vid_ra, vid_de, vid_cursor, vid_hblank, vid_vblank,
           vid_hsync, vid_vsync, video_blank, video_gfx, vram_data, chrom_data,
    input  vram_addr, chrom_addr, pix, out_hblank, out_vblank, out_hsync, out_vsync
  );

  modport slave (
    input  vid_ma, vid_ra, vid_de, vid_cursor, vid_hblank, vid_vblank,
           vid_hsync, vid_vsync, video_blank, video_gfx, vram_data, chrom_data,
    output vram_addr, chrom_addr, pix, out_hblank, out_vblank, out_hsync, out_vsync
  );
endinterface

// File: rtl/pet2001_char_shifter.sv
// PET character generator: screen-code fetch, glyph lookup and MSB-first pixel serialiser.
// Latency: 2 ce_1m periods from vid_ma to first pixel; blank/sync outputs delayed identically.
// No backpressure: free-running pipeline advanced only by ce_1m / ce_pix, holds otherwise.
module pet2001_char_shifter #(
  parameter int VRAM_AW    = 10,
  parameter int PIPE_DEPTH = 2,
  parameter bit INVERT_EN  = 1'b1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   ce_1m,
  input  logic                   ce_pix,
  pet2001_char_shifter_if.slave  vid
);

  // The fetch/lookup/load structure below is hard-wired for two stages.
  if (PIPE_DEPTH != 2) begin : g_bad_depth
    $error("pet2001_char_shifter: PIPE_DEPTH must be 2");
  end

  // Control carried alongside the VRAM fetch
  typedef struct packed {
    logic       de;
    logic       cursor;
    logic [4:0] ra;
    logic       hb;
    logic       vb;
    logic       hs;
    logic       vs;
    logic       blank;
  } stage1_t;

  // Control carried alongside the ROM lookup; low row bits are already consumed
  typedef struct packed {
    logic       de;
    logic       cursor;
    logic [1:0] ra_hi;
    logic       hb;
    logic       vb;
    logic       hs;
    logic       vs;
    logic       blank;
  } stage2_t;

  stage1_t            d1;
  stage2_t            d2;
  logic               inv;
  logic [7:0]         sr;
  logic [VRAM_AW-1:0] vram_addr_q;
  logic [10:0]        chrom_addr_q;
  logic               out_hblank_q;
  logic               out_vblank_q;
  logic               out_hsync_q;
  logic               out_vsync_q;
  logic               show;
  logic [7:0]         glyph;

  // Upper matrix-address bits fall outside the video RAM; addresses simply wrap.
  logic unused_ma;
  assign unused_ma = ^vid.vid_ma[13:VRAM_AW];

  // Visible only inside the display window, outside forced blank, and within glyph rows 0-7.
  always_comb begin
    show  = d2.de & ~d2.blank & (d2.ra_hi == 2'b00);
    glyph = vid.chrom_data ^ {8{inv}} ^ {8{d2.cursor}};
  end

  // Stage 0: present the matrix address to VRAM and latch the cell's control.
  always_ff @(posedge clk) begin
    if (reset) begin
      vram_addr_q <= '0;
      d1          <= '0;
    end else if (ce_1m) begin
      vram_addr_q <= vid.vid_ma[VRAM_AW-1:0];
      d1          <= {vid.vid_de, vid.vid_cursor, vid.vid_ra, vid.vid_hblank,
                      vid.vid_vblank, vid.vid_hsync, vid.vid_vsync, vid.video_blank};
    end
  end

  // Stage 1: screen code is back from VRAM; form the glyph ROM address and inverse flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      chrom_addr_q <= '0;
      inv          <= 1'b0;
      d2           <= '0;
    end else if (ce_1m) begin
      chrom_addr_q <= {vid.video_gfx, vid.vram_data[6:0], d1.ra[2:0]};
      inv          <= INVERT_EN & vid.vram_data[7];
      d2           <= {d1.de, d1.cursor, d1.ra[4:3], d1.hb, d1.vb, d1.hs, d1.vs, d1.blank};
    end
  end

  // Stage 2: load the glyph row (or zeros) and shift it out; a load wins over a shift.
  always_ff @(posedge clk) begin
    if (reset) begin
      sr           <= '0;
      out_hblank_q <= 1'b0;
      out_vblank_q <= 1'b0;
      out_hsync_q  <= 1'b0;
      out_vsync_q  <= 1'b0;
    end else if (ce_1m) begin
      sr           <= show ? glyph : 8'h00;
      out_hblank_q <= d2.hb;
      out_vblank_q <= d2.vb;
      out_hsync_q  <= d2.hs;
      out_vsync_q  <= d2.vs;
    end else if (ce_pix) begin
      sr           <= {sr[6:0], 1'b0};
    end
  end

  assign vid.vram_addr  = vram_addr_q;
  assign vid.chrom_addr = chrom_addr_q;
  assign vid.pix        = sr[7];
  assign vid.out_hblank = out_hblank_q;
  assign vid.out_vblank = out_vblank_q;
  assign vid.out_hsync  = out_hsync_q;
  assign vid.out_vsync  = out_vsync_q;

endmodule
